// File: rtl/idu_hazard_ctrl.sv
// Decode-stage hazard and issue controller: 3-entry EX/MEM/WB scoreboard, operand forwarding,
// load-use stalls, drain before serializing instructions, and IF/ID kill after an EX redirect.
module idu_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned KILL_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_load,
  input  logic              id_serialize,
  input  logic              ex_ready,
  input  logic              ex_redirect,
  output logic              id_stall,
  output logic              ex_bubble,
  output logic              id_flush,
  output logic [1:0]        fwd_rs1_sel,
  output logic [1:0]        fwd_rs2_sel,
  output logic              issue,
  output logic [1:0]        state
);

  typedef struct packed {
    logic              v;
    logic              w;
    logic              ld;
    logic [REG_AW-1:0] rd;
  } sb_entry_t;

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StDrain = 2'd1,
    StKill  = 2'd2
  } state_e;

  localparam logic [1:0] KillLoad = 2'(KILL_CYCLES - 1);

  sb_entry_t  ex_q, mem_q, wb_q;
  sb_entry_t  ex_d, mem_d, wb_d;
  state_e     state_q, state_d;
  logic [1:0] kill_cnt_q, kill_cnt_d;

  logic       ex_hit1, mem_hit1, wb_hit1;
  logic       ex_hit2, mem_hit2, wb_hit2;
  logic [1:0] sel1, sel2;
  logic       sb_busy, load_use, drain_req;
  logic       stall_c, bubble_c, flush_c, issue_c;

  function automatic logic src_hit(input sb_entry_t e, input logic [REG_AW-1:0] src,
                                   input logic use_src);
    return e.v && e.w && (e.rd == src) && use_src && (src != '0);
  endfunction

  function automatic logic [1:0] fwd_pick(input logic h_ex, input logic h_mem, input logic h_wb);
    logic [1:0] sel;
    sel = 2'd0;
    if (h_ex)       sel = 2'd1;
    else if (h_mem) sel = 2'd2;
    else if (h_wb)  sel = 2'd3;
    return sel;
  endfunction

  always_comb begin
    ex_hit1  = src_hit(ex_q,  id_rs1, id_use_rs1);
    mem_hit1 = src_hit(mem_q, id_rs1, id_use_rs1);
    wb_hit1  = src_hit(wb_q,  id_rs1, id_use_rs1);
    ex_hit2  = src_hit(ex_q,  id_rs2, id_use_rs2);
    mem_hit2 = src_hit(mem_q, id_rs2, id_use_rs2);
    wb_hit2  = src_hit(wb_q,  id_rs2, id_use_rs2);
    sel1     = fwd_pick(ex_hit1, mem_hit1, wb_hit1);
    sel2     = fwd_pick(ex_hit2, mem_hit2, wb_hit2);
  end

  // Redirect overrides everything: a pending stall or drain belongs to the wrong path.
  always_comb begin
    sb_busy    = ex_q.v || mem_q.v || wb_q.v;
    load_use   = ex_q.ld && (ex_hit1 || ex_hit2);
    drain_req  = id_valid && id_serialize && sb_busy;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;
    issue_c    = 1'b0;
    state_d    = state_q;
    kill_cnt_d = kill_cnt_q;
    if (ex_redirect) begin
      flush_c    = 1'b1;
      state_d    = StKill;
      kill_cnt_d = KillLoad;
    end else begin
      unique case (state_q)
        StRun: begin
          if (id_valid && load_use) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end else if (drain_req) begin
            stall_c  = 1'b1;
            bubble_c = ex_ready;
          end else begin
            issue_c  = id_valid && ex_ready;
          end
          if (drain_req) state_d = StDrain;
        end
        StDrain: begin
          if (sb_busy) begin
            stall_c  = 1'b1;
            bubble_c = ex_ready;
          end else begin
            issue_c  = id_valid && ex_ready;
            state_d  = StRun;
          end
        end
        StKill: begin
          flush_c = 1'b1;
          if (kill_cnt_q == 2'd0) state_d = StRun;
          else                    kill_cnt_d = kill_cnt_q - 2'd1;
        end
        default: state_d = StRun;
      endcase
    end
  end

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (ex_ready) begin
      wb_d  = mem_q;
      mem_d = ex_q;
      ex_d  = '0;
      if (issue_c) begin
        ex_d = '{v: 1'b1, w: id_wen && (id_rd != '0), ld: id_load, rd: id_rd};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      state_q    <= StRun;
      kill_cnt_q <= 2'd0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      state_q    <= state_d;
      kill_cnt_q <= kill_cnt_d;
    end
  end

  // Outputs are combinational, so gate them with reset to read 0 the moment reset asserts.
  assign id_stall    = reset && stall_c;
  assign ex_bubble   = reset && bubble_c;
  assign id_flush    = reset && flush_c;
  assign issue       = reset && issue_c;
  assign fwd_rs1_sel = reset ? sel1 : 2'd0;
  assign fwd_rs2_sel = reset ? sel2 : 2'd0;
  assign state       = reset ? state_q : 2'd0;

endmodule

// File: tb/tb_idu_hazard_ctrl.sv
// Bench for idu_hazard_ctrl: directed hazard scenarios plus random traffic, checked every cycle
// against an age-ordered history model of the pipeline.
module tb_idu_hazard_ctrl;

  localparam int unsigned AW = 5;
  localparam int unsigned K  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          id_valid, id_use_rs1, id_use_rs2, id_wen, id_load, id_serialize;
  logic [AW-1:0] id_rs1, id_rs2, id_rd;
  logic          ex_ready, ex_redirect;
  logic          id_stall, ex_bubble, id_flush, issue;
  logic [1:0]    fwd_rs1_sel, fwd_rs2_sel, state;

  idu_hazard_ctrl #(.REG_AW(AW), .KILL_CYCLES(K)) dut (
    .clock       (clock),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_wen      (id_wen),
    .id_load     (id_load),
    .id_serialize(id_serialize),
    .ex_ready    (ex_ready),
    .ex_redirect (ex_redirect),
    .id_stall    (id_stall),
    .ex_bubble   (ex_bubble),
    .id_flush    (id_flush),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .issue       (issue),
    .state       (state)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: hist[0] is the instruction that most recently entered EX.
  typedef struct {
    bit v;
    bit wen;
    bit ld;
    int rd;
  } rec_t;

  localparam int MRun = 0, MDrain = 1, MKill = 2;

  rec_t hist[$];
  int   m_mode, m_kill, n_mode, n_kill;
  int   e_f1, e_f2, e_state;
  bit   e_stall, e_bubble, e_flush, e_issue, c_ready;
  rec_t c_new;

  task automatic model_reset();
    rec_t empty;
    empty = '{v: 0, wen: 0, ld: 0, rd: 0};
    hist = {};
    for (int i = 0; i < 3; i++) hist.push_back(empty);
    m_mode = MRun;
    m_kill = 0;
  endtask

  function automatic int fwd_of(input int src, input bit use_src);
    if (!use_src || src == 0) return 0;
    for (int i = 0; i < 3; i++)
      if (hist[i].v && hist[i].wen && hist[i].rd == src) return i + 1;
    return 0;
  endfunction

  task automatic model_eval();
    bit busy, lu;
    busy = 0;
    for (int i = 0; i < 3; i++) busy |= hist[i].v;
    e_f1     = fwd_of(int'(id_rs1), id_use_rs1);
    e_f2     = fwd_of(int'(id_rs2), id_use_rs2);
    lu       = hist[0].ld && (e_f1 == 1 || e_f2 == 1);
    e_state  = m_mode;
    e_stall  = 0;
    e_bubble = 0;
    e_flush  = 0;
    e_issue  = 0;
    if (ex_redirect || m_mode == MKill) begin
      e_flush = 1;
    end else if (m_mode == MDrain) begin
      if (busy) begin
        e_stall  = 1;
        e_bubble = ex_ready;
      end else begin
        e_issue = id_valid && ex_ready;
      end
    end else if (id_valid && lu) begin
      e_stall  = 1;
      e_bubble = 1;
    end else if (id_valid && id_serialize && busy) begin
      e_stall  = 1;
      e_bubble = ex_ready;
    end else begin
      e_issue = id_valid && ex_ready;
    end
    n_mode = m_mode;
    n_kill = m_kill;
    if (ex_redirect) begin
      n_mode = MKill;
      n_kill = K - 1;
    end else if (m_mode == MKill) begin
      if (m_kill == 0) n_mode = MRun;
      else             n_kill = m_kill - 1;
    end else if (m_mode == MDrain) begin
      if (!busy) n_mode = MRun;
    end else if (id_valid && id_serialize && busy) begin
      n_mode = MDrain;
    end
    c_ready = ex_ready;
    c_new   = '{v: e_issue, wen: id_wen, ld: id_load, rd: int'(id_rd)};
  endtask

  task automatic model_commit();
    m_mode = n_mode;
    m_kill = n_kill;
    if (c_ready) begin
      hist.push_front(c_new);
      void'(hist.pop_back());
    end
  endtask

  // Called at a negedge: apply inputs, settle, compare every output against the model.
  task automatic drive(input int v, input int rs1, input int u1, input int rs2, input int u2,
                       input int rd, input int wen, input int ld, input int ser, input int rdy,
                       input int redir);
    id_valid     = (v != 0);
    id_rs1       = AW'(rs1);
    id_use_rs1   = (u1 != 0);
    id_rs2       = AW'(rs2);
    id_use_rs2   = (u2 != 0);
    id_rd        = AW'(rd);
    id_wen       = (wen != 0);
    id_load      = (ld != 0);
    id_serialize = (ser != 0);
    ex_ready     = (rdy != 0);
    ex_redirect  = (redir != 0);
    #1;
    model_eval();
    check_eq("fwd_rs1_sel", int'(fwd_rs1_sel), e_f1);
    check_eq("fwd_rs2_sel", int'(fwd_rs2_sel), e_f2);
    check_eq("id_stall",    int'(id_stall),    int'(e_stall));
    check_eq("ex_bubble",   int'(ex_bubble),   int'(e_bubble));
    check_eq("id_flush",    int'(id_flush),    int'(e_flush));
    check_eq("issue",       int'(issue),       int'(e_issue));
    check_eq("state",       int'(state),       e_state);
  endtask

  task automatic tick();
    @(posedge clock);
    model_commit();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tick();
    end
  endtask

  task automatic fill3();
    for (int i = 1; i <= 3; i++) begin
      drive(1, 0, 0, 0, 0, i, 1, 0, 0, 1, 0);
      tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_stall"},  int'(id_stall),    0);
    check_eq({tag, "_bubble"}, int'(ex_bubble),   0);
    check_eq({tag, "_flush"},  int'(id_flush),    0);
    check_eq({tag, "_issue"},  int'(issue),       0);
    check_eq({tag, "_fwd1"},   int'(fwd_rs1_sel), 0);
    check_eq({tag, "_fwd2"},   int'(fwd_rs2_sel), 0);
    check_eq({tag, "_state"},  int'(state),       0);
  endtask

  initial begin
    model_reset();
    // Reset with busy-looking inputs: every output must read 0.
    id_valid = 1; id_rs1 = 5'd3; id_rs2 = 5'd4; id_use_rs1 = 1; id_use_rs2 = 1;
    id_rd = 5'd3; id_wen = 1; id_load = 1; id_serialize = 1; ex_ready = 1; ex_redirect = 1;
    @(negedge clock);
    #1;
    check_reset_outputs("rst_init");
    @(negedge clock);
    reset = 1'b1;
    idle(3);

    // Forwarding distance: 0..3 unrelated instructions between producer and consumer.
    for (int gap = 0; gap < 4; gap++) begin
      idle(3);
      drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 1, 0);
      tick();
      for (int g = 0; g < gap; g++) begin
        drive(1, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        tick();
      end
      drive(1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0);
      check_eq("dist_rs1", int'(fwd_rs1_sel), (gap < 3) ? gap + 1 : 0);
      check_eq("dist_rs2", int'(fwd_rs2_sel), (gap < 3) ? gap + 1 : 0);
      check_eq("dist_nostall", int'(id_stall), 0);
      tick();
    end

    // Load-use: one bubble, then issue with MEM forwarding.
    idle(3);
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 1, 0);
    tick();
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0, 1, 0);
    check_eq("lu_stall", int'(id_stall), 1);
    check_eq("lu_bubble", int'(ex_bubble), 1);
    check_eq("lu_noissue", int'(issue), 0);
    tick();
    drive(1, 7, 1, 0, 1, 8, 1, 0, 0, 1, 0);
    check_eq("lu_issue", int'(issue), 1);
    check_eq("lu_fwd1", int'(fwd_rs1_sel), 2);
    check_eq("lu_fwd2", int'(fwd_rs2_sel), 0);
    tick();

    // x0 producer (even a load) is never forwarded and never stalls.
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    tick();
    drive(1, 0, 1, 0, 1, 4, 1, 0, 0, 1, 0);
    check_eq("x0_stall", int'(id_stall), 0);
    check_eq("x0_fwd1", int'(fwd_rs1_sel), 0);
    tick();

    // Serializing instruction with a full scoreboard drains for 3 cycles.
    idle(3);
    fill3();
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      check_eq("drain_stall", int'(id_stall), 1);
      if (c > 0) check_eq("drain_state", int'(state), 1);
      tick();
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    check_eq("drain_issue", int'(issue), 1);
    check_eq("drain_release", int'(id_stall), 0);
    tick();
    idle(1);

    // Redirect: K kill cycles, older entries keep forwarding.
    idle(3);
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 1, 0);
    tick();
    drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    check_eq("kill_flush0", int'(id_flush), 1);
    check_eq("kill_noissue", int'(issue), 0);
    check_eq("kill_fwd_ex", int'(fwd_rs1_sel), 1);
    tick();
    for (int k = 0; k < int'(K); k++) begin
      drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 1, 0);
      check_eq("kill_state", int'(state), 2);
      check_eq("kill_flush", int'(id_flush), 1);
      if (k == 0) check_eq("kill_fwd_mem", int'(fwd_rs1_sel), 2);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("kill_exit", int'(state), 0);
    tick();

    // Redirect abandons a drain in progress.
    idle(3);
    fill3();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    check_eq("drain_redir_stall", int'(id_stall), 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("drain_redir_state", int'(state), 2);
    tick();
    idle(4);

    // Asynchronous reset mid-drain.
    fill3();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    tick();
    drive(1, 2, 1, 3, 1, 0, 0, 0, 1, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clock);
    @(negedge clock);
    model_reset();
    reset = 1'b1;
    drive(0, 2, 1, 3, 1, 0, 0, 0, 0, 1, 0);
    check_eq("rst_state", int'(state), 0);
    check_eq("rst_sb_empty", int'(fwd_rs1_sel), 0);
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(int'($urandom_range(0, 9) < 8), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 9) < 7),
            int'($urandom_range(0, 3) == 0), int'($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 9) < 8), int'($urandom_range(0, 19) == 0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
